// File: rtl/fp_unpack_pkg.sv
// fp_unpack_pkg: shared types and format helpers for the FPU operand unpacker.
//   fp_format_e          : supported IEEE-754 formats
//   fp_class_t           : one-hot operand class {zero, subnormal, normal, inf, qnan, snan}
//   fp_exp_bits/fp_man_bits/fp_width/fp_lz_bits : field widths derived from a format
package fp_unpack_pkg;

   typedef enum logic [1:0] {
      FP32 = 2'd0,
      FP64 = 2'd1,
      FP16 = 2'd2
   } fp_format_e;

   typedef struct packed {
      logic zero;
      logic subnormal;
      logic normal;
      logic inf;
      logic qnan;
      logic snan;
   } fp_class_t;

   function automatic int unsigned fp_exp_bits(fp_format_e fmt);
      case (fmt)
         FP64:    return 32'd11;
         FP16:    return 32'd5;
         default: return 32'd8;
      endcase
   endfunction

   function automatic int unsigned fp_man_bits(fp_format_e fmt);
      case (fmt)
         FP64:    return 32'd52;
         FP16:    return 32'd10;
         default: return 32'd23;
      endcase
   endfunction

   function automatic int unsigned fp_width(fp_format_e fmt);
      return 32'd1 + fp_exp_bits(fmt) + fp_man_bits(fmt);
   endfunction

   // Leading-zero count of the mantissa field ranges 0..MANT_WIDTH-1.
   function automatic int unsigned fp_lz_bits(fp_format_e fmt);
      return $clog2(fp_man_bits(fmt));
   endfunction

endpackage

// File: rtl/fp_unpack_if.sv
// fp_unpack_if: operand-in / unpacked-result-out bus of fp_unpack.
//   valid_i, ready_o, operand_i              : upstream handshake and packed operand
//   valid_o, ready_i, sign_o, exp_o, mant_o,
//   class_o                                  : downstream handshake and unpacked fields
//   modport slave  : the unpack unit
//   modport master : the environment driving it
interface fp_unpack_if #(
   parameter fp_unpack_pkg::fp_format_e FP_FORMAT = fp_unpack_pkg::FP32
);
   import fp_unpack_pkg::*;

   localparam int unsigned EXP_WIDTH  = fp_exp_bits(FP_FORMAT);
   localparam int unsigned MANT_WIDTH = fp_man_bits(FP_FORMAT);
   localparam int unsigned FP_WIDTH   = fp_width(FP_FORMAT);

   logic                  valid_i;
   logic                  ready_o;
   logic [FP_WIDTH-1:0]   operand_i;
   logic                  valid_o;
   logic                  ready_i;
   logic                  sign_o;
   logic [EXP_WIDTH+1:0]  exp_o;
   logic [MANT_WIDTH:0]   mant_o;
   fp_class_t             class_o;

   modport slave (
      input  valid_i, operand_i, ready_i,
      output ready_o, valid_o, sign_o, exp_o, mant_o, class_o
   );

   modport master (
      output valid_i, operand_i, ready_i,
      input  ready_o, valid_o, sign_o, exp_o, mant_o, class_o
   );

endinterface

// File: rtl/fp_unpack_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   i_data : input vector
//   o_cnt  : number of zeros above the highest set bit (0 when i_data == 0)
module fp_lzc #(
   parameter int unsigned WIDTH = 23,
   parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] i_data,
   output logic [CNT_W-1:0] o_cnt
);

   // Scan upward so the highest set bit determines the final count.
   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         o_cnt = i_data[i] ? CNT_W'(int'(WIDTH) - 1 - i) : o_cnt;
      end
   end

endmodule

// File: rtl/fp_unpack.sv
// fp_unpack: FPU operand front end. Unpacks an IEEE-754 operand into sign, extended
// biased exponent (EXP_WIDTH+2 bits, two's complement), mantissa with explicit hidden
// bit and a one-hot class. Subnormals are normalized (mantissa MSB = 1, exponent <= 0).
// Two-stage valid/ready pipeline, latency 2, throughput 1 per cycle.
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   bus     : fp_unpack_if.slave (operand in, unpacked result out)
// Configuration macro FP_UNPACK_DAZ_EN: when defined, subnormal inputs are classed as
// zero (exp 0, mant 0, sign kept).
module fp_unpack
   import fp_unpack_pkg::*;
#(
   parameter fp_format_e FP_FORMAT = FP32
) (
   input  logic          clk_i,
   input  logic          reset_i,
   fp_unpack_if.slave    bus
);

   localparam int unsigned EXP_W  = fp_exp_bits(FP_FORMAT);
   localparam int unsigned MANT_W = fp_man_bits(FP_FORMAT);
   localparam int unsigned FP_W   = fp_width(FP_FORMAT);
   localparam int unsigned LZ_W   = fp_lz_bits(FP_FORMAT);
   localparam int unsigned XEXP_W = EXP_W + 2;

   // Field split of the incoming operand
   logic              w_sign;
   logic [EXP_W-1:0]  w_exp;
   logic [MANT_W-1:0] w_mant;
   logic [LZ_W-1:0]   w_lz;
   fp_class_t         w_cls;
   logic              w_adv1;
   logic              w_adv2;

   // Stage 1 registers
   logic              r_v1;
   logic              r_s1_sign;
   logic [EXP_W-1:0]  r_s1_exp;
   logic [MANT_W-1:0] r_s1_mant;
   logic [LZ_W-1:0]   r_s1_lz;
   fp_class_t         r_s1_cls;

   // Stage 2 (output) registers
   logic              r_v2;
   logic              r_s2_sign;
   logic [XEXP_W-1:0] r_s2_exp;
   logic [MANT_W:0]   r_s2_mant;
   fp_class_t         r_s2_cls;

   // Stage 2 combinational results
   logic [XEXP_W-1:0] w_xexp;
   logic [MANT_W:0]   w_xmant;

   assign w_sign = bus.operand_i[FP_W-1];
   assign w_exp  = bus.operand_i[FP_W-2 -: EXP_W];
   assign w_mant = bus.operand_i[MANT_W-1:0];

   fp_lzc #(.WIDTH(MANT_W), .CNT_W(LZ_W)) u_lzc (
      .i_data (w_mant),
      .o_cnt  (w_lz)
   );

   // A full output stage frees up when downstream takes it; stage 1 frees up behind it.
   assign w_adv2 = !r_v2 || bus.ready_i;
   assign w_adv1 = !r_v1 || w_adv2;

   // Operand classification from the exponent/mantissa fields
   always_comb begin
      w_cls = '0;
      if (&w_exp) begin
         if (w_mant == '0) begin
            w_cls.inf = 1'b1;
         end else if (w_mant[MANT_W-1]) begin
            w_cls.qnan = 1'b1;
         end else begin
            w_cls.snan = 1'b1;
         end
      end else if (w_exp == '0) begin
         if (w_mant == '0) begin
            w_cls.zero = 1'b1;
         end else begin
`ifdef FP_UNPACK_DAZ_EN
            w_cls.zero = 1'b1;
`else
            w_cls.subnormal = 1'b1;
`endif
         end
      end else begin
         w_cls.normal = 1'b1;
      end
   end

   // Stage 1 register: capture fields, class and leading-zero count
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_v1      <= 1'b0;
         r_s1_sign <= 1'b0;
         r_s1_exp  <= '0;
         r_s1_mant <= '0;
         r_s1_lz   <= '0;
         r_s1_cls  <= '0;
      end else if (w_adv1) begin
         r_v1 <= bus.valid_i;
         if (bus.valid_i) begin
            r_s1_sign <= w_sign;
            r_s1_exp  <= w_exp;
            r_s1_mant <= w_mant;
            r_s1_lz   <= w_lz;
            r_s1_cls  <= w_cls;
         end
      end
   end

   // Stage 2 datapath: normalization shift and per-class exponent/mantissa select
   always_comb begin
      w_xexp  = '0;
      w_xmant = '0;
      if (r_s1_cls.normal) begin
         w_xexp  = {2'b00, r_s1_exp};
         w_xmant = {1'b1, r_s1_mant};
      end else if (r_s1_cls.subnormal) begin
         // Shift the top set bit into the hidden-bit position; exponent becomes -lz.
         w_xexp  = XEXP_W'(0) - XEXP_W'(r_s1_lz);
         w_xmant = {r_s1_mant, 1'b0} << r_s1_lz;
      end else if (r_s1_cls.inf) begin
         w_xexp  = {2'b00, {EXP_W{1'b1}}};
         w_xmant = '0;
      end else if (r_s1_cls.qnan || r_s1_cls.snan) begin
         w_xexp  = {2'b00, {EXP_W{1'b1}}};
         w_xmant = {1'b1, r_s1_mant};
      end else begin
         w_xexp  = '0;
         w_xmant = '0;
      end
   end

   // Stage 2 register: outputs only change when a new result is moved in
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_v2      <= 1'b0;
         r_s2_sign <= 1'b0;
         r_s2_exp  <= '0;
         r_s2_mant <= '0;
         r_s2_cls  <= '0;
      end else if (w_adv2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_s2_sign <= r_s1_sign;
            r_s2_exp  <= w_xexp;
            r_s2_mant <= w_xmant;
            r_s2_cls  <= r_s1_cls;
         end
      end
   end

   assign bus.ready_o = w_adv1;
   assign bus.valid_o = r_v2;
   assign bus.sign_o  = r_s2_sign;
   assign bus.exp_o   = r_s2_exp;
   assign bus.mant_o  = r_s2_mant;
   assign bus.class_o = r_s2_cls;

endmodule

// File: tb/tb_fp_unpack.sv
// tb_fp_unpack: directed self-checking bench for fp_unpack (FP32).
// Honors FP_UNPACK_DAZ_EN for the expected subnormal results.
module tb_fp_unpack;
   import fp_unpack_pkg::*;

   localparam logic [5:0] C_ZERO = 6'b100000;
   localparam logic [5:0] C_SUB  = 6'b010000;
   localparam logic [5:0] C_NORM = 6'b001000;
   localparam logic [5:0] C_INF  = 6'b000100;
   localparam logic [5:0] C_QNAN = 6'b000010;
   localparam logic [5:0] C_SNAN = 6'b000001;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   fp_unpack_if #(.FP_FORMAT(FP32)) bus ();

   fp_unpack #(.FP_FORMAT(FP32)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] op;
      logic        sgn;
      logic [9:0]  ex;
      logic [23:0] mn;
      logic [5:0]  cl;
   } vec_t;

   logic [5:0] got_cls;
   assign got_cls = bus.class_o;

   // Compare all output fields against an expected vector (inline in each test via this macro-free block)
   task automatic test_reset();
      rst           = 1'b1;
      bus.valid_i   = 1'b1;
      bus.operand_i = 32'h3F800000;
      bus.ready_i   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.valid_i = 1'b0;
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
      total++; if ({bus.sign_o, bus.exp_o, bus.mant_o, got_cls} !== 41'd0) begin bad++; $display("FAIL reset_data: got %h want 0", {bus.sign_o, bus.exp_o, bus.mant_o, got_cls}); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", bus.valid_o); end
   endtask

   task automatic test_classes();
      vec_t v [0:10];
      v[0]  = '{32'h3F800000, 1'b0, 10'd127,  24'h800000, C_NORM};
`ifdef FP_UNPACK_DAZ_EN
      v[1]  = '{32'h00000001, 1'b0, 10'h000,  24'h000000, C_ZERO};
      v[2]  = '{32'h007FFFFF, 1'b0, 10'h000,  24'h000000, C_ZERO};
      v[3]  = '{32'h00000003, 1'b0, 10'h000,  24'h000000, C_ZERO};
      v[4]  = '{32'h80400000, 1'b1, 10'h000,  24'h000000, C_ZERO};
`else
      v[1]  = '{32'h00000001, 1'b0, 10'h3EA,  24'h800000, C_SUB};
      v[2]  = '{32'h007FFFFF, 1'b0, 10'h000,  24'hFFFFFE, C_SUB};
      v[3]  = '{32'h00000003, 1'b0, 10'h3EB,  24'hC00000, C_SUB};
      v[4]  = '{32'h80400000, 1'b1, 10'h000,  24'h800000, C_SUB};
`endif
      v[5]  = '{32'h80000000, 1'b1, 10'h000,  24'h000000, C_ZERO};
      v[6]  = '{32'h7F800001, 1'b0, 10'h0FF,  24'h800001, C_SNAN};
      v[7]  = '{32'h7FC00000, 1'b0, 10'h0FF,  24'hC00000, C_QNAN};
      v[8]  = '{32'hFF800000, 1'b1, 10'h0FF,  24'h000000, C_INF};
      v[9]  = '{32'hC0490FDB, 1'b1, 10'd128,  24'hC90FDB, C_NORM};
      v[10] = '{32'h00800000, 1'b0, 10'd1,    24'h800000, C_NORM};
      bus.ready_i = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         bus.valid_i   = 1'b1;
         bus.operand_i = v[i].op;
         @(negedge clk);
         bus.valid_i   = 1'b0;
         total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL lat1_%0d: valid_o got %b want 0", i, bus.valid_o); end
         @(negedge clk);
         total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL lat2_%0d: valid_o got %b want 1", i, bus.valid_o); end
         total++; if (bus.sign_o !== v[i].sgn) begin bad++; $display("FAIL sign_%0d: got %b want %b", i, bus.sign_o, v[i].sgn); end
         total++; if (bus.exp_o !== v[i].ex) begin bad++; $display("FAIL exp_%0d: got %h want %h", i, bus.exp_o, v[i].ex); end
         total++; if (bus.mant_o !== v[i].mn) begin bad++; $display("FAIL mant_%0d: got %h want %h", i, bus.mant_o, v[i].mn); end
         total++; if (got_cls !== v[i].cl) begin bad++; $display("FAIL class_%0d: got %b want %b", i, got_cls, v[i].cl); end
      end
      @(negedge clk);
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL drain_idle: valid_o got %b want 0", bus.valid_o); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ops [0:2];
      logic [9:0]  exps [0:2];
      logic        sgns [0:2];
      ops[0] = 32'h3F800000; exps[0] = 10'd127; sgns[0] = 1'b0;
      ops[1] = 32'h40000000; exps[1] = 10'd128; sgns[1] = 1'b0;
      ops[2] = 32'hBF800000; exps[2] = 10'd127; sgns[2] = 1'b1;
      bus.ready_i = 1'b0;
      @(negedge clk);
      bus.valid_i = 1'b1; bus.operand_i = ops[0];
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready_a: got %b want 1", bus.ready_o); end
      @(negedge clk);
      bus.operand_i = ops[1];
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready_b: got %b want 1", bus.ready_o); end
      @(negedge clk);
      bus.operand_i = ops[2];
      // Both stages full, output stalled: C must wait.
      for (int k = 0; k < 3; k++) begin
         total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL b2b_full_ready_%0d: got %b want 0", k, bus.ready_o); end
         total++; if (bus.valid_o !== 1'b1 || bus.exp_o !== exps[0] || bus.sign_o !== sgns[0]) begin
            bad++; $display("FAIL b2b_hold_a_%0d: got v=%b e=%h s=%b want v=1 e=%h s=%b", k, bus.valid_o, bus.exp_o, bus.sign_o, exps[0], sgns[0]);
         end
         if (k < 2) @(negedge clk);
      end
      bus.ready_i = 1'b1;
      #1;
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready_comb: got %b want 1", bus.ready_o); end
      for (int k = 0; k < 3; k++) begin
         total++; if (bus.valid_o !== 1'b1 || bus.exp_o !== exps[k] || bus.sign_o !== sgns[k] || bus.mant_o !== 24'h800000) begin
            bad++; $display("FAIL b2b_out_%0d: got v=%b e=%h s=%b m=%h want v=1 e=%h s=%b m=800000", k, bus.valid_o, bus.exp_o, bus.sign_o, bus.mant_o, exps[k], sgns[k]);
         end
         @(negedge clk);
         bus.valid_i = 1'b0;
      end
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL b2b_no_dup: valid_o got %b want 0", bus.valid_o); end
   endtask

   task automatic test_reset_midflight();
      bus.ready_i = 1'b0;
      @(negedge clk);
      bus.valid_i = 1'b1; bus.operand_i = 32'h3F800000;
      @(negedge clk);
      bus.operand_i = 32'h40000000;
      @(negedge clk);
      bus.valid_i = 1'b0;
      total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL rmid_full: ready_o got %b want 0", bus.ready_o); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.ready_i = 1'b1;
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", bus.valid_o); end
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", bus.ready_o); end
      bus.valid_i = 1'b1; bus.operand_i = 32'hFF800000;
      @(negedge clk);
      bus.valid_i = 1'b0;
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rmid_lat1: valid_o got %b want 0", bus.valid_o); end
      @(negedge clk);
      total++; if (bus.valid_o !== 1'b1 || bus.sign_o !== 1'b1 || bus.exp_o !== 10'h0FF || got_cls !== C_INF) begin
         bad++; $display("FAIL rmid_first: got v=%b s=%b e=%h c=%b want v=1 s=1 e=0ff c=%b", bus.valid_o, bus.sign_o, bus.exp_o, got_cls, C_INF);
      end
      @(negedge clk);
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rmid_no_stale: valid_o got %b want 0", bus.valid_o); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.valid_i   = 1'b0;
      bus.operand_i = 32'h0;
      bus.ready_i   = 1'b1;
      rst           = 1'b1;
      test_reset();
      test_classes();
      test_back_to_back();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
